// File: rtl/cpu_pkg.sv
// Shared CPU definitions: memory-access FSM states, word width, and the
// byte-address to word-index helper used by both fetch- and data-side memories.
package cpu_pkg;

  localparam int WORD_W = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

  // Drops the byte offset; callers keep as many low bits as their depth needs.
  function automatic logic [29:0] word_index(input logic [31:0] byte_addr);
    return byte_addr[31:2];
  endfunction

endpackage

// File: rtl/dmem_array.sv
// Single-port synchronous RAM, DEPTH words of WORD_W bits, with a registered
// read. Contents are not reset so the array maps onto block RAM.
module dmem_array
  import cpu_pkg::*;
#(
  parameter int DEPTH = 256
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic                     re,
  input  logic [$clog2(DEPTH)-1:0] addr,
  input  logic [WORD_W-1:0]        wdata,
  output logic [WORD_W-1:0]        rdata
);

  logic [WORD_W-1:0] mem [DEPTH];
  logic [WORD_W-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
    if (re) begin
      rdata_q <= mem[addr];
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: one load/store at a time, fixed access latency,
// valid/ready on both request and response. Optional misaligned-address
// error reporting is enabled by defining DMEM_MISALIGN_CHECK_EN.
module dmem_responder
  import cpu_pkg::*;
#(
  parameter int DEPTH   = 256,
  parameter int LATENCY = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [31:0]       req_addr,
  input  logic [WORD_W-1:0] req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [WORD_W-1:0] resp_rdata,
  output logic              resp_err,
  output logic              busy
);

  localparam int AW = $clog2(DEPTH);

  state_e            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              we_q, we_d;
  logic [AW-1:0]     idx_q, idx_d;
  logic [WORD_W-1:0] wdata_q, wdata_d;
  logic              mis_q, mis_d;
  logic              load_q, load_d;

  logic [29:0]       req_word;
  logic              req_mis;
  logic              access;
  logic              ram_we;
  logic              ram_re;
  logic [WORD_W-1:0] ram_rdata;
  logic              unused_addr_bits;

  assign req_word = word_index(req_addr);

`ifdef DMEM_MISALIGN_CHECK_EN
  assign req_mis = (req_addr[1:0] != 2'b00);
`else
  assign req_mis = 1'b0;
`endif

  // Upper bits beyond the array depth wrap away by design.
  assign unused_addr_bits = ^{req_word[29:AW], req_addr[1:0]};

  assign access = (state_q == WAIT) && (cnt_q == 4'd0);
  assign ram_we = access && we_q && !mis_q;
  assign ram_re = access && !we_q && !mis_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    idx_d   = idx_q;
    wdata_d = wdata_q;
    mis_d   = mis_q;
    load_d  = load_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          we_d    = req_we;
          idx_d   = req_word[AW-1:0];
          wdata_d = req_wdata;
          mis_d   = req_mis;
          cnt_d   = 4'(LATENCY - 1);
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          load_d  = !we_q && !mis_q;
          state_d = RESP;
        end
      end
      RESP: begin
        if (resp_ready) begin
          load_d  = 1'b0;
          mis_d   = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      idx_q   <= '0;
      wdata_q <= '0;
      mis_q   <= 1'b0;
      load_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      idx_q   <= idx_d;
      wdata_q <= wdata_d;
      mis_q   <= mis_d;
      load_q  <= load_d;
    end
  end

  dmem_array #(
    .DEPTH(DEPTH)
  ) u_array (
    .clk  (clk),
    .we   (ram_we),
    .re   (ram_re),
    .addr (idx_q),
    .wdata(wdata_q),
    .rdata(ram_rdata)
  );

  // Read data lives in the RAM output register; gating by state keeps the
  // response clean for stores, errors and reset without resetting the RAM.
  assign req_ready  = (state_q == IDLE);
  assign resp_valid = (state_q == RESP);
  assign busy       = (state_q != IDLE);
  assign resp_rdata = (resp_valid && load_q) ? ram_rdata : '0;
  assign resp_err   = resp_valid && mis_q;

endmodule
